// File: rtl/reset_sequencer.sv
// Staged reset sequencer: synchronizes POR release, then releases the SRAM
// macro reset and, after a gap, the test core reset; supports software re-sequencing.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       por,
  input  logic       sw_rst_req,
  output logic       sram_rst,
  output logic       core_rst,
  output logic       core_rstn,
  output logic       ready,
  output logic       rst_cause,
  output logic [1:0] state
);

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] SRAM_UP = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  // Parameter sanity: a bad configuration stops elaboration instead of misbehaving.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
      CNT_W < 1 || CNT_W > 31 ||
      (longint'(1) << CNT_W) <= longint'(HOLD_CYCLES) ||
      (longint'(1) << CNT_W) <= longint'(STAGE_GAP)) begin : g_param_check
    $error("reset_sequencer: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   por_sync;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic [1:0]             state_next;
  logic                   cause_next;

  assign por_sync = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge por) begin
    if (por) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  // A software request outranks the terminal count; requests are ignored
  // until the synchronized POR release so the cause stays "power-on".
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cause_next = rst_cause;
    if (por_sync) begin
      state_next = HOLD;
      cnt_next   = '0;
    end else if (sw_rst_req) begin
      state_next = HOLD;
      cnt_next   = '0;
      cause_next = 1'b1;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_next = SRAM_UP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        SRAM_UP: begin
          if (cnt == GAP_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_next = '0;
        end
        default: begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so each one is its own flop.
  always_ff @(posedge clk or posedge por) begin
    if (por) begin
      state     <= HOLD;
      cnt       <= '0;
      rst_cause <= 1'b0;
      sram_rst  <= 1'b1;
      core_rst  <= 1'b1;
      core_rstn <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      rst_cause <= cause_next;
      sram_rst  <= (state_next == HOLD);
      core_rst  <= (state_next != RUN);
      core_rstn <= (state_next == RUN);
      ready     <= (state_next == RUN);
    end
  end

endmodule
